// File: rtl/vga_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_reader
// Brief    : VGA 640x480@60 timing plus frame-buffer scan-out with registered
//            pixel/sync outputs. Build macro VGA_SCALE2X_EN selects 2x pixel
//            doubling of the 320x240 buffer; without it the image maps 1:1.
// Revision : 1.0
// ============================================================================
module vga_scan_reader #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_out,
    output logic [7:0]  row_read,
    output logic [8:0]  col_read,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least wide enough to slice the buffer address bits.
    localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
`ifndef VGA_SCALE2X_EN
    localparam logic [HW-1:0] C_IMG_W    = HW'(320);
    localparam logic [VW-1:0] C_IMG_H    = VW'(240);
`endif

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;

    logic          w_tick;
    logic          w_active;
    logic          w_in_img;
    logic          w_hs_n;
    logic          w_vs_n;

    always_comb begin
        w_tick  = (div_q == C_DIV_LAST);
        div_d   = w_tick ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (w_tick) begin
            if (h_cnt_q == C_H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == C_V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_active = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
        w_hs_n   = !((h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END));
        w_vs_n   = !((v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END));
`ifdef VGA_SCALE2X_EN
        w_in_img = w_active;
        row_read = w_in_img ? v_cnt_q[8:1] : 8'd0;
        col_read = w_in_img ? h_cnt_q[9:1] : 9'd0;
`else
        w_in_img = w_active && (h_cnt_q < C_IMG_W) && (v_cnt_q < C_IMG_H);
        row_read = w_in_img ? v_cnt_q[7:0] : 8'd0;
        col_read = w_in_img ? h_cnt_q[8:0] : 9'd0;
`endif
    end

    // Colour and sync are captured from the same scan position, one tick late.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (w_tick) begin
            rgb_d = w_in_img ? pixel_out : 12'd0;
            hs_d  = w_hs_n;
            vs_d  = w_vs_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb_q   <= 12'd0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    // Gated by rst so a permanently high tick (CLK_DIV=1) cannot pulse in reset.
    assign frame_start = w_tick && (h_cnt_q == '0) && (v_cnt_q == '0) && !rst;

    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule
`default_nettype wire

// File: doc/vga_scan_reader.md
# vga_scan_reader

Read-side companion of the VGA frame buffer RAM: generates 640x480@60 Hz VGA timing, drives the buffer's read address (`row_read`, `col_read`) from the scan position, and registers the returned 12-bit pixel onto the RGB outputs. The pixel is aligned with `vga_hs`/`vga_vs`. It sits between the buffer RAM's asynchronous read port and the board VGA connector. The masking pipeline writes the 320x240 image through the RAM's write port; this block scans it out continuously.

## Interface
Parameters:
- `CLK_DIV`, 2, system clocks per pixel tick (2 gives 25 MHz pixel rate from a 50 MHz `clk`); must be 1 or more.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48, horizontal timing in pixel ticks.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33, vertical timing in lines.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `pixel_out`  in  12  pixel from buffer RAM, `{R[11:8],G[7:4],B[3:0]}`; combinational function of the read address.
- `row_read`  out  8  buffer read row, 0..239.
- `col_read`  out  9  buffer read column, 0..319.
- `vga_r`, `vga_g`, `vga_b`  out  4 each  colour outputs.
- `vga_hs`, `vga_vs`  out  1 each  sync outputs, active-low.
- `frame_start`  out  1  one-`clk` pulse on the first pixel tick of each frame.

## Operation
- Pixel tick: a divider counts 0..`CLK_DIV`-1. `tick` is high when the divider is at `CLK_DIV`-1. All counters and output registers update only on `tick`. `frame_start` is the one exception.
- `h_cnt` counts 0..799 and wraps to 0. On that wrap, `v_cnt` increments 0..524 and wraps to 0.
- Active region: `h_cnt` < 640 and `v_cnt` < 480.
- HS is low for `h_cnt` in 656..751. VS is low for `v_cnt` in 490..491.
- Read address (see Configuration):
  - `row_read` = `v_cnt`>>1 and `col_read` = `h_cnt`>>1 when active.
  - Address is held at 0/0 when not active.
- Output stage: on `tick`, the RGB outputs register `pixel_out` if the current position is active, otherwise 0. `vga_hs`/`vga_vs` register the sync decodes of the same position, so colour and sync stay aligned.
- `frame_start` asserts for one `clk` in the cycle where `tick` occurs with `h_cnt`=0 and `v_cnt`=0.

## Timing
- Reset values (asynchronous, immediate):
  - divider, `h_cnt`, `v_cnt` = 0
  - `row_read`, `col_read` = 0
  - `vga_r`/`vga_g`/`vga_b` = 0
  - `vga_hs`, `vga_vs` = 1
  - `frame_start` = 0
- After reset release, the first `tick` occurs `CLK_DIV` clocks later.
- The read address is combinational from the counters. It is valid for the whole tick period.
- The RAM read is combinational. The output is registered on the next `tick`, giving exactly 1 pixel tick of latency from counter position to pins. Sync has the same latency.
- Line = 800 ticks. Frame = 525 lines = 420000 ticks (840000 `clk` at `CLK_DIV`=2).
- Wrap: `h_cnt`=799 and `v_cnt`=524 on a `tick` moves both counters to 0 and starts a new frame.
- Reset mid-frame:
  - outputs go to their reset values at once;
  - timing restarts at 0/0, with no partial line completed;
  - `frame_start` fires on the first `tick` after release.
- `CLK_DIV`=1: `tick` is constantly high and every counter advances each `clk`.

## Configuration
- `VGA_SCALE2X_EN` defined (default build): the 320x240 buffer is pixel-doubled to fill 640x480. Address = position>>1 on both axes, as above.
- Undefined: 1:1 mapping.
  - The image occupies `h_cnt` < 320, `v_cnt` < 240.
  - Address = `v_cnt`[7:0], `h_cnt`[8:0] inside the image.
  - Address is 0/0 elsewhere.
  - RGB = 0 in the rest of the active area.
  - Sync timing is unchanged.

## Test plan
- Reset: assert `rst` mid-line with `pixel_out`=12'hFFF. Required: RGB=0 and HS=VS=1 immediately. The first `frame_start` comes `CLK_DIV` clocks after release.
- Line/frame period: free-run. Required: HS period 800 ticks, HS low for exactly 96 ticks starting at `h_cnt`=656, VS low for 2 lines, `frame_start` spacing 840000 clocks at `CLK_DIV`=2.
- Address/scaling, using a RAM model with pixel = {row[3:0], col[7:0]}:
  - at `h_cnt`=7, `v_cnt`=5: `col_read`=3, `row_read`=2;
  - the RGB output one tick later = 12'h203.
- Blanking: `pixel_out` forced to 12'hCCC. Required: RGB=0 for `h_cnt` 640..799 and all of `v_cnt` 480..524; address 0/0 there.
- Wrap: at `h_cnt`=639, `v_cnt`=479 read address = 239/319; the next frame's first active pixel is read from 0/0.
- Macro off: at `h_cnt`=330, `v_cnt`=10 with `pixel_out`=12'hBBB. Required: RGB=0. At `h_cnt`=3, `v_cnt`=5: address 5/3 and RGB=12'hBBB one tick later.
